// File: rtl/dmem_responder.sv
// Handshaked fixed-latency word memory for MEM-stage loads and stores.
// One access in flight; stall_o holds the pipeline until the single-cycle ack.
module dmem_responder #(
   parameter int unsigned DEPTH   = 32,
   parameter int unsigned LATENCY = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic        ready_o,
   output logic        ack_o,
   output logic [31:0] rdata_o,
   output logic        err_o,
   output logic        stall_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam bit          ONE_CYCLE = (LATENCY == 1);
   localparam logic [CW-1:0] CNT_INIT = CW'((LATENCY >= 2) ? (LATENCY - 2) : 0);
   localparam logic [29:0] DEPTH_W = 30'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t          state_q;
   logic [CW-1:0]   cnt_q;
   logic            we_q;
   logic [AW-1:0]   idx_q;
   logic            lerr_q;
   logic [31:0]     wdata_q;
   logic            ack_q;
   logic            err_q;
   logic [31:0]     rdata_q;
   logic [31:0]     mem_q [DEPTH];

   logic            in_err_d;
   logic [AW-1:0]   in_idx_d;
   logic            go_resp_d;
   logic            sel_we_d;
   logic            sel_err_d;
   logic [AW-1:0]   sel_idx_d;
   logic [31:0]     sel_wdata_d;
   logic            mem_we_d;

   assign in_err_d = (|addr_i[1:0]) | (addr_i[31:2] >= DEPTH_W);
   assign in_idx_d = addr_i[AW+1:2];

   // With LATENCY == 1 the response is produced on the accepting edge itself,
   // so the live request fields are used instead of the not-yet-latched copies.
   always_comb begin
      go_resp_d   = 1'b0;
      sel_we_d    = we_q;
      sel_err_d   = lerr_q;
      sel_idx_d   = idx_q;
      sel_wdata_d = wdata_q;
      if (state_q == S_IDLE) begin
         go_resp_d   = req_i & ONE_CYCLE;
         sel_we_d    = we_i;
         sel_err_d   = in_err_d;
         sel_idx_d   = in_idx_d;
         sel_wdata_d = wdata_i;
      end else if (state_q == S_WAIT) begin
         go_resp_d   = (cnt_q == '0);
      end
   end

   // Reset held low must never commit a write, even with a request pending.
   assign mem_we_d = rst_i & go_resp_d & sel_we_d & ~sel_err_d;

   always_ff @(posedge clk_i) begin
      if (mem_we_d) begin
         mem_q[sel_idx_d] <= sel_wdata_d;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         idx_q   <= '0;
         lerr_q  <= 1'b0;
         wdata_q <= '0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (req_i) begin
                  we_q    <= we_i;
                  idx_q   <= in_idx_d;
                  lerr_q  <= in_err_d;
                  wdata_q <= wdata_i;
                  if (ONE_CYCLE) begin
                     state_q <= S_RESP;
                  end else begin
                     cnt_q   <= CNT_INIT;
                     state_q <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               if (cnt_q == '0) begin
                  state_q <= S_RESP;
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end
            S_RESP: begin
               state_q <= S_IDLE;
               ack_q   <= 1'b0;
               err_q   <= 1'b0;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase

         if (go_resp_d) begin
            ack_q <= 1'b1;
            err_q <= sel_err_d;
            if (!sel_we_d) begin
               rdata_q <= sel_err_d ? '0 : mem_q[sel_idx_d];
            end
         end
      end
   end

   assign ready_o = (state_q == S_IDLE);
   assign ack_o   = ack_q;
   assign err_o   = err_q;
   assign rdata_o = rdata_q;
   assign stall_o = req_i & ~ack_q;

endmodule
